multdiv_ctrl: RTL and testbench



---
 rtl/multdiv_ctrl.sv | 151 +++++++++++++++
 tb/tb_multdiv_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multdiv_ctrl : issues mul/div from DX, stalls the pipe, hands result to XM
// Rev 1.0
// ----------------------------------------------------------------------------
module multdiv_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] insn_dx,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        stall_ext,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        busy
);

  localparam logic [4:0]       OPC_RTYPE = 5'b00000;
  localparam logic [4:0]       ALU_MUL   = 5'b00110;
  localparam logic [4:0]       ALU_DIV   = 5'b00111;
  localparam logic [4:0]       RD_STATUS = 5'd30;
  localparam logic [31:0]      EXC_MUL   = 32'd4;
  localparam logic [31:0]      EXC_DIV   = 32'd5;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic [31:0]      result_q, result_d;
  logic [4:0]       rd_q, rd_d;
  logic [4:0]       rd_out_q, rd_out_d;
  logic             is_div_q, is_div_d;

  logic w_is_rtype;
  logic w_is_mul;
  logic w_is_div;
  logic w_issue;
  logic w_unused_insn;

  assign w_is_rtype    = (insn_dx[31:27] == OPC_RTYPE);
  assign w_is_mul      = w_is_rtype & (insn_dx[6:2] == ALU_MUL);
  assign w_is_div      = w_is_rtype & (insn_dx[6:2] == ALU_DIV);
  assign w_unused_insn = ^{insn_dx[21:7], insn_dx[1:0]};

  // Reset also masks the combinational start pulse so nothing issues while held.
  assign w_issue = (state_q == S_IDLE) & (w_is_mul | w_is_div) & ~stall_ext & ~reset;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    is_div_d = is_div_q;

    case (state_q)
      S_IDLE: begin
        if (w_issue) begin
          opa_d    = operandA;
          opb_d    = operandB;
          rd_d     = insn_dx[26:22];
          is_div_d = w_is_div;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end
      end

      S_BUSY: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (md_ready && !md_exception) begin
          result_d = md_result;
          rd_out_d = rd_q;
          state_d  = S_DONE;
        end else if (md_ready || (cnt_q == CNT_LAST)) begin
          // Exception and timeout both report through rstatus.
          result_d = is_div_q ? EXC_DIV : EXC_MUL;
          rd_out_d = RD_STATUS;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        if (!stall_ext) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      is_div_q <= is_div_d;
    end
  end

  assign ctrl_MULT    = w_issue & w_is_mul;
  assign ctrl_DIV     = w_issue & w_is_div;
  assign stall        = w_issue | (state_q == S_BUSY);
  assign busy         = (state_q == S_BUSY);
  assign result_valid = (state_q == S_DONE);
  assign md_operandA  = opa_q;
  assign md_operandB  = opb_q;
  assign result       = result_q;
  assign rd_out       = rd_out_q;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_multdiv_ctrl : decode vectors, directed corner sequences, random transactions
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_multdiv_ctrl;

  localparam int TIMEOUT = 40;

  logic        clock;
  logic        reset;
  logic [31:0] insn_dx;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        stall_ext;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        busy;

  int n_pass = 0;
  int n_tot  = 0;

  multdiv_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .insn_dx(insn_dx),
    .operandA(operandA), .operandB(operandB), .stall_ext(stall_ext),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .stall(stall), .result_valid(result_valid), .result(result),
    .rd_out(rd_out), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mk_insn(input logic [4:0] opc, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] alu);
    return {opc, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_mult"},  ctrl_MULT, 0);
    chk({tag, "_div"},   ctrl_DIV, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_rv"},    result_valid, 0);
    chk({tag, "_busy"},  busy, 0);
  endtask

  // Transaction-level model: the unit answers on BUSY cycle d (1-based);
  // answers later than TIMEOUT are never seen and the op times out instead.
  task automatic run_op(input string tag, input logic is_div, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input int d,
                        input logic exc, input logic [31:0] mdres, input int ext);
    int          nb;
    logic        exc_eff;
    logic [31:0] exp_res;
    logic [4:0]  exp_rd;
    nb      = (d <= TIMEOUT) ? d : TIMEOUT;
    exc_eff = exc || (d > TIMEOUT);
    exp_res = exc_eff ? (is_div ? 32'd5 : 32'd4) : mdres;
    exp_rd  = exc_eff ? 5'd30 : rd;

    @(negedge clock);
    insn_dx = mk_insn(5'b00000, rd, 5'd1, 5'd2, is_div ? 5'b00111 : 5'b00110);
    operandA = a; operandB = b; stall_ext = 1'b0;
    md_ready = 1'b0; md_exception = 1'b0; md_result = $urandom;
    #1;
    chk({tag, "_issue_mult"}, ctrl_MULT, !is_div);
    chk({tag, "_issue_div"},  ctrl_DIV, is_div);
    chk({tag, "_issue_stall"}, stall, 1);
    chk({tag, "_issue_busy"},  busy, 0);

    for (int k = 1; k <= nb; k++) begin
      @(negedge clock);
      operandA = $urandom; operandB = $urandom;
      stall_ext    = 1'($urandom_range(0, 1));
      md_ready     = (k == d);
      md_exception = (k == d) ? exc : 1'($urandom_range(0, 1));
      md_result    = (k == d) ? mdres : $urandom;
      #1;
      chk($sformatf("%s_busy%0d_busy", tag, k), busy, 1);
      chk($sformatf("%s_busy%0d_stall", tag, k), stall, 1);
      chk($sformatf("%s_busy%0d_start", tag, k), {ctrl_MULT, ctrl_DIV}, 0);
      chk($sformatf("%s_busy%0d_rv", tag, k), result_valid, 0);
      if (k == 1) begin
        chk({tag, "_opA"}, md_operandA, a);
        chk({tag, "_opB"}, md_operandB, b);
      end
    end

    for (int e = 0; e <= ext; e++) begin
      @(negedge clock);
      stall_ext    = (e < ext);
      md_ready     = 1'($urandom_range(0, 1));
      md_exception = 1'($urandom_range(0, 1));
      md_result    = $urandom;
      #1;
      chk($sformatf("%s_done%0d_rv", tag, e), result_valid, 1);
      chk($sformatf("%s_done%0d_stall", tag, e), stall, 0);
      chk($sformatf("%s_done%0d_busy", tag, e), busy, 0);
      chk($sformatf("%s_done%0d_start", tag, e), {ctrl_MULT, ctrl_DIV}, 0);
      chk($sformatf("%s_done%0d_result", tag, e), result, exp_res);
      chk($sformatf("%s_done%0d_rd", tag, e), rd_out, exp_rd);
    end

    // Next instruction is not mul/div; a stray md_ready must be ignored.
    @(negedge clock);
    insn_dx = mk_insn(5'b00000, 5'd8, 5'd1, 5'd2, 5'b00000);
    stall_ext = 1'b0; md_ready = 1'b1; md_exception = 1'b0;
    #1;
    chk_idle_outs({tag, "_after"});
    md_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] insn;
    logic        ext;
    logic        e_mult;
    logic        e_div;
    logic        e_stall;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{mk_insn(5'b00000, 5'd3, 5'd1, 5'd2, 5'b00000), 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{mk_insn(5'b00000, 5'd3, 5'd1, 5'd2, 5'b00110), 1'b0, 1'b1, 1'b0, 1'b1};
    vt[2] = '{mk_insn(5'b00000, 5'd5, 5'd1, 5'd2, 5'b00111), 1'b0, 1'b0, 1'b1, 1'b1};
    vt[3] = '{mk_insn(5'b00000, 5'd3, 5'd1, 5'd2, 5'b00110), 1'b1, 1'b0, 1'b0, 1'b0};
    vt[4] = '{mk_insn(5'b00000, 5'd5, 5'd1, 5'd2, 5'b00111), 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5] = '{mk_insn(5'b00101, 5'd3, 5'd1, 5'd2, 5'b00110), 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6] = '{mk_insn(5'b00000, 5'd3, 5'd1, 5'd2, 5'b01000), 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7] = '{mk_insn(5'b10000, 5'd5, 5'd1, 5'd2, 5'b00111), 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; stall_ext = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
    md_result = 32'h0; operandA = 32'h0; operandB = 32'h0;
    insn_dx = mk_insn(5'b00000, 5'd3, 5'd1, 5'd2, 5'b00000);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    chk_idle_outs("reset");
    chk("reset_result", result, 0);
    chk("reset_rd", rd_out, 0);
    chk("reset_opA", md_operandA, 0);

    // Decode table: reset is raised before each edge so nothing actually issues.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      insn_dx = vt[i].insn; stall_ext = vt[i].ext;
      #1;
      chk($sformatf("vec%0d_mult", i), ctrl_MULT, vt[i].e_mult);
      chk($sformatf("vec%0d_div", i), ctrl_DIV, vt[i].e_div);
      chk($sformatf("vec%0d_stall", i), stall, vt[i].e_stall);
      reset = 1'b1;
      @(negedge clock);
      insn_dx = 32'h0; stall_ext = 1'b0;
      reset = 1'b0;
    end

    run_op("mul42",   1'b0, 5'd3, 32'd6, 32'd7, 17, 1'b0, 32'd42, 0);
    run_op("divzero", 1'b1, 5'd5, 32'd9, 32'd0, 32, 1'b1, 32'hdead_beef, 0);
    run_op("timeout", 1'b0, 5'd7, 32'd3, 32'd4, 1000, 1'b0, 32'd0, 0);
    run_op("lastcyc", 1'b0, 5'd9, 32'd1, 32'd2, TIMEOUT, 1'b0, 32'd123, 0);
    run_op("extstl",  1'b1, 5'd4, 32'd100, 32'd7, 5, 1'b0, 32'd14, 3);
    run_op("first",   1'b1, 5'd31, 32'hffff_ffff, 32'd1, 1, 1'b0, 32'hffff_ffff, 0);

    // Reset in the middle of BUSY, then a late md_ready from the abandoned op.
    @(negedge clock);
    insn_dx = mk_insn(5'b00000, 5'd6, 5'd1, 5'd2, 5'b00110);
    operandA = 32'h55; operandB = 32'h66; stall_ext = 1'b0;
    #1;
    chk("rstmid_issue", ctrl_MULT, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      #1;
      chk($sformatf("rstmid_busy%0d", k), busy, 1);
    end
    reset = 1'b1;
    #1;
    chk_idle_outs("rstmid_async");
    chk("rstmid_opA", md_operandA, 0);
    chk("rstmid_opB", md_operandB, 0);
    chk("rstmid_result", result, 0);
    chk("rstmid_rd", rd_out, 0);
    @(negedge clock);
    reset = 1'b0;
    insn_dx = 32'h0;
    @(negedge clock);
    md_ready = 1'b1; md_exception = 1'b0; md_result = 32'h1234;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("rstmid_stray%0d", k), {result_valid, busy, stall}, 0);
      @(negedge clock);
      md_ready = 1'b0;
    end

    for (int t = 0; t < 20; t++) begin
      run_op($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             $urandom, $urandom, int'($urandom_range(1, 45)),
             ($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
